flags_update_ctrl: RTL and testbench
====================================

// Module: flags_update_ctrl
//
// PURPOSE
//  Owns the write port of the architectural FLAGS register: arbitrates ALU
//  result updates, POPF/IRET whole-register loads and interrupt-entry
//  sequencing into one flags_in/update_flags pair per cycle.
//  Captures the pre-interrupt FLAGS image for the push, then clears TF/IF.
//  Generates the one-instruction interrupt shadow after IF goes 0->1.
//  Sits between the microcode/ALU, the interrupt controller and the
//  Flags register.
//
// PARAMETERS
//  FLAGS_RESET  16'h0002  value returned on saved_flags after reset
//  SHADOW_LEN   2         instr_boundary pulses irq_inhibit is held for
//
// PORTS
//  clk             in   1   clock
//  reset           in   1   asynchronous, active-high reset
//  flags_cur       in   16  current FLAGS register output
//  alu_valid       in   1   ALU/microcode flag update request
//  alu_flags       in   16  ALU flag values, architectural bit positions
//  alu_update      in   9   per-flag write enables (CF,PF,AF,ZF,SF,TF,IF,DF,OF = bit 0..8)
//  alu_ready       out  1   ALU request accepted this cycle
//  load_valid      in   1   POPF/IRET full load request
//  load_flags      in   16  value to load
//  load_ready      out  1   load accepted this cycle
//  int_req         in   1   interrupt entry request (level)
//  int_ack         out  1   1-cycle pulse: entry done, saved_flags valid
//  saved_flags     out  16  FLAGS image captured at interrupt entry
//  instr_boundary  in   1   1-cycle pulse at each instruction retire
//  irq_inhibit     out  1   interrupt shadow active
//  flags_in        out  16  to Flags register data input
//  update_flags    out  9   to Flags register per-flag enables
//
// BEHAVIOUR
//  Bit positions: CF0 PF2 AF4 ZF6 SF7 TF8 IF9 DF10 OF11; enable bits 0..8 as above.
//  FSM: IDLE -> SAVE -> CLEAR -> IDLE.
//   - IDLE: int_req=1 -> SAVE; no write issued that cycle.
//   - SAVE: saved_flags <= flags_cur; writes from the previous cycle are
//     already visible. No write issued.
//   - CLEAR: update_flags = TF|IF (9'h060), flags_in = 0; int_ack = 1;
//     next state IDLE.
//   - The requester drops int_req on the edge where int_ack=1. If int_req is
//     still high in IDLE, a new entry starts.
//  Arbitration, valid/ready; transfer occurs when both are high:
//   - Priority: int_req > load > alu.
//   - load_ready = IDLE & !int_req.
//   - alu_ready  = IDLE & !int_req & !load_valid.
//   - Ready is combinational. Requesters hold valid and data stable until
//     ready is seen.
//   - Load transfer: flags_in = load_flags, update_flags = 9'h1FF.
//   - ALU transfer: flags_in = alu_flags, update_flags = alu_update.
//   - No transfer: update_flags = 0, flags_in = 0.
//  Latency: 0 cycles to the Flags input; committed at the next edge.
//   Exactly one source is written per cycle.
//  Interrupt shadow:
//   - A committed write with the IF enable set, flags_in[9]=1 and
//     flags_cur[9]=0 sets irq_inhibit=1 next cycle and loads a counter
//     with SHADOW_LEN.
//   - Each instr_boundary decrements the counter; at 0, irq_inhibit
//     clears next cycle.
//   - A new 0->1 IF write while the shadow is active reloads the counter.
//   - Entering CLEAR clears irq_inhibit and the counter.
//   - instr_boundary in the same cycle as the setting write is ignored.
//  Reset (async):
//   - state = IDLE, saved_flags = FLAGS_RESET, counter = 0.
//   - All outputs 0: int_ack, irq_inhibit, ready, update_flags, flags_in.
//  Reset mid-sequence (SAVE/CLEAR) abandons entry: no int_ack, no TF/IF write.
//
// TESTING
//  1. ALU only: alu_valid=1, alu_update=9'h001, alu_flags=16'h0001
//     -> alu_ready=1, update_flags=9'h001, flags_in=16'h0001 same cycle.
//  2. Load+ALU same cycle: load_ready=1, alu_ready=0, update_flags=9'h1FF.
//     Next cycle ALU is accepted.
//  3. Interrupt entry with flags_cur=16'h0302 -> SAVE then CLEAR.
//     saved_flags=16'h0302, update_flags=9'h060, flags_in=0,
//     int_ack pulse on the 2nd cycle after int_req.
//  4. int_req with load_valid held: load_ready=0 for 3 cycles,
//     accepted in IDLE after int_req drops.
//  5. STI (IF 0->1): irq_inhibit=1 next cycle; clears after the 2nd
//     instr_boundary. A second STI mid-shadow restarts the count.
//  6. Assert reset during SAVE -> int_ack never pulses, state IDLE,
//     saved_flags=16'h0002, all ready=0 while reset high.

Source files
------------

// File: rtl/flags_update_ctrl.sv
// Write-port controller for the architectural FLAGS register: arbitrates ALU updates,
// POPF/IRET loads and interrupt entry, and generates the post-STI interrupt shadow.
module flags_update_ctrl #(
    parameter logic [15:0] FLAGS_RESET = 16'h0002,
    parameter int unsigned SHADOW_LEN  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] flags_cur,
    input  logic        alu_valid,
    input  logic [15:0] alu_flags,
    input  logic [8:0]  alu_update,
    output logic        alu_ready,
    input  logic        load_valid,
    input  logic [15:0] load_flags,
    output logic        load_ready,
    input  logic        int_req,
    output logic        int_ack,
    output logic [15:0] saved_flags,
    input  logic        instr_boundary,
    output logic        irq_inhibit,
    output logic [15:0] flags_in,
    output logic [8:0]  update_flags
);

    localparam int       CNT_W    = (SHADOW_LEN < 1) ? 1 : $clog2(SHADOW_LEN + 1);
    localparam int       EN_IF    = 6;
    localparam int       BIT_IF   = 9;
    localparam logic [8:0] UPD_TFIF = 9'h060;
    localparam logic [8:0] UPD_ALL  = 9'h1FF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_CLEAR
    } state_t;

    state_t             state_reg;
    logic [15:0]        saved_reg;
    logic               int_ack_reg;
    logic               inhibit_reg;
    logic [CNT_W-1:0]   shadow_cnt_reg;
    logic [CNT_W-1:0]   shadow_cnt_next;
    logic               if_rise;

    // Only one source drives the Flags write port in any cycle; interrupt entry wins.
    always_comb begin
        load_ready   = 1'b0;
        alu_ready    = 1'b0;
        flags_in     = '0;
        update_flags = '0;
        if (state_reg == ST_CLEAR) begin
            update_flags = UPD_TFIF;
        end else if (state_reg == ST_IDLE && !reset && !int_req) begin
            load_ready = 1'b1;
            alu_ready  = !load_valid;
            if (load_valid) begin
                flags_in     = load_flags;
                update_flags = UPD_ALL;
            end else if (alu_valid) begin
                flags_in     = alu_flags;
                update_flags = alu_update;
            end
        end
    end

    assign if_rise = update_flags[EN_IF] & flags_in[BIT_IF] & ~flags_cur[BIT_IF];

    // A fresh IF 0->1 write takes precedence over a boundary in the same cycle.
    always_comb begin
        shadow_cnt_next = shadow_cnt_reg;
        if (state_reg == ST_SAVE) begin
            shadow_cnt_next = '0;
        end else if (if_rise) begin
            shadow_cnt_next = CNT_W'(SHADOW_LEN);
        end else if (instr_boundary && shadow_cnt_reg != '0) begin
            shadow_cnt_next = shadow_cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            saved_reg      <= FLAGS_RESET;
            int_ack_reg    <= 1'b0;
            inhibit_reg    <= 1'b0;
            shadow_cnt_reg <= '0;
        end else begin
            int_ack_reg    <= 1'b0;
            shadow_cnt_reg <= shadow_cnt_next;
            inhibit_reg    <= (shadow_cnt_next != '0);
            case (state_reg)
                ST_IDLE: begin
                    if (int_req) begin
                        state_reg <= ST_SAVE;
                    end
                end
                ST_SAVE: begin
                    saved_reg   <= flags_cur;
                    int_ack_reg <= 1'b1;
                    state_reg   <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign int_ack     = int_ack_reg;
    assign saved_flags = saved_reg;
    assign irq_inhibit = inhibit_reg;

endmodule

// File: tb/tb_flags_update_ctrl.sv
// Scoreboard bench for flags_update_ctrl: the bench plays the Flags register, the
// requesters and a reference model; a negedge monitor checks every cycle and write.
module tb_flags_update_ctrl;

    localparam int SHADOW_LEN = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] flags_cur;
    logic        alu_valid;
    logic [15:0] alu_flags;
    logic [8:0]  alu_update;
    logic        alu_ready;
    logic        load_valid;
    logic [15:0] load_flags;
    logic        load_ready;
    logic        int_req;
    logic        int_ack;
    logic [15:0] saved_flags;
    logic        instr_boundary;
    logic        irq_inhibit;
    logic [15:0] flags_in;
    logic [8:0]  update_flags;

    flags_update_ctrl #(.FLAGS_RESET(16'h0002), .SHADOW_LEN(SHADOW_LEN)) dut (
        .clk(clk), .reset(reset), .flags_cur(flags_cur),
        .alu_valid(alu_valid), .alu_flags(alu_flags), .alu_update(alu_update),
        .alu_ready(alu_ready), .load_valid(load_valid), .load_flags(load_flags),
        .load_ready(load_ready), .int_req(int_req), .int_ack(int_ack),
        .saved_flags(saved_flags), .instr_boundary(instr_boundary),
        .irq_inhibit(irq_inhibit), .flags_in(flags_in), .update_flags(update_flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        lr;
        logic        ar;
        logic        inh;
        logic        wr;
        logic [15:0] fin;
    } cyc_t;

    typedef struct packed {
        logic [8:0]  upd;
        logic [15:0] data;
        logic        ack;
        logic [15:0] saved;
    } wr_t;

    cyc_t cyc_q[$];
    wr_t  wr_q[$];

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    // Reference model: entry phase (0 none, 1 capture, 2 clear), flags, saved image,
    // and boundaries still owed before the shadow ends.
    int          phase_m;
    logic [15:0] flags_m;
    logic [15:0] saved_m;
    int          shadow_m;
    int          pos_m[9] = '{0, 2, 4, 6, 7, 8, 9, 10, 11};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic iq, input logic lv, input logic [15:0] ld,
                        input logic av, input logic [15:0] af, input logic [8:0] au,
                        input logic ib, output logic acc_l, output logic acc_a,
                        output logic acked);
        cyc_t c;
        wr_t  w;
        logic sti;
        @(posedge clk);
        #1;
        int_req        = iq;
        load_valid     = lv;
        load_flags     = ld;
        alu_valid      = av;
        alu_flags      = af;
        alu_update     = au;
        instr_boundary = ib;
        flags_cur      = flags_m;

        c       = '0;
        w       = '0;
        c.lr    = (phase_m == 0) && !iq;
        c.ar    = c.lr && !lv;
        c.inh   = (shadow_m > 0);
        acc_l   = c.lr && lv;
        acc_a   = c.ar && av;
        acked   = (phase_m == 2);
        w.saved = saved_m;
        if (phase_m == 2) begin
            w.upd = 9'h060;
            w.ack = 1'b1;
        end else if (acc_l) begin
            w.upd  = 9'h1FF;
            w.data = ld;
        end else if (acc_a) begin
            w.upd  = au;
            w.data = af;
        end
        c.wr  = (w.upd != 9'h000) || w.ack;
        c.fin = w.data;
        cyc_q.push_back(c);
        if (c.wr) wr_q.push_back(w);

        sti = w.upd[6] && w.data[9] && !flags_m[9];
        if (phase_m == 1) begin
            saved_m  = flags_m;
            shadow_m = 0;
        end else if (sti) begin
            shadow_m = SHADOW_LEN;
        end else if (ib && shadow_m > 0) begin
            shadow_m--;
        end
        for (int i = 0; i < 9; i++) begin
            if (w.upd[i]) flags_m[pos_m[i]] = w.data[pos_m[i]];
        end
        if (phase_m == 0) phase_m = iq ? 1 : 0;
        else if (phase_m == 1) phase_m = 2;
        else phase_m = 0;
    endtask

    cyc_t mc;
    wr_t  mw;
    logic mdw;

    always @(negedge clk) begin
        if (mon_en && cyc_q.size() > 0) begin
            mc = cyc_q.pop_front();
            mdw = (update_flags != 9'h000) || int_ack;
            chk("load_ready", 32'(load_ready), 32'(mc.lr));
            chk("alu_ready", 32'(alu_ready), 32'(mc.ar));
            chk("irq_inhibit", 32'(irq_inhibit), 32'(mc.inh));
            chk("write_present", 32'(mdw), 32'(mc.wr));
            if (!mc.wr) chk("flags_in_idle", 32'(flags_in), 32'(mc.fin));
            if (mc.wr && wr_q.size() > 0) begin
                mw = wr_q.pop_front();
                if (mdw) begin
                    chk("update_flags", 32'(update_flags), 32'(mw.upd));
                    chk("flags_in", 32'(flags_in), 32'(mw.data));
                    chk("int_ack", 32'(int_ack), 32'(mw.ack));
                    if (mw.ack) chk("saved_flags", 32'(saved_flags), 32'(mw.saved));
                    $display("WR upd=%h data=%h ack=%0d saved=%h", update_flags, flags_in,
                             int_ack, saved_flags);
                end
            end
        end
    end

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_load_ready"}, 32'(load_ready), 32'd0);
        chk({tag, "_alu_ready"}, 32'(alu_ready), 32'd0);
        chk({tag, "_int_ack"}, 32'(int_ack), 32'd0);
        chk({tag, "_irq_inhibit"}, 32'(irq_inhibit), 32'd0);
        chk({tag, "_update_flags"}, 32'(update_flags), 32'd0);
        chk({tag, "_flags_in"}, 32'(flags_in), 32'd0);
        chk({tag, "_saved_flags"}, 32'(saved_flags), 32'h0002);
    endtask

    task automatic model_reset();
        phase_m  = 0;
        saved_m  = 16'h0002;
        shadow_m = 0;
    endtask

    logic        al, aa, ak;
    logic        r_iq, r_lv, r_av;
    logic [15:0] r_ld, r_af;
    logic [8:0]  r_au;

    initial begin
        flags_m = 16'h0002;
        model_reset();
        reset          = 1'b1;
        flags_cur      = flags_m;
        int_req        = 1'b0;
        load_valid     = 1'b1;
        load_flags     = 16'h1234;
        alu_valid      = 1'b1;
        alu_flags      = 16'hFFFF;
        alu_update     = 9'h1FF;
        instr_boundary = 1'b0;
        #3;
        reset_outputs_check("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset      = 1'b0;
        load_valid = 1'b0;
        alu_valid  = 1'b0;
        mon_en     = 1'b1;

        // ALU-only update, then load and ALU competing in one cycle
        step(0, 0, 16'h0000, 1, 16'h0001, 9'h001, 0, al, aa, ak);
        step(0, 1, 16'h0A55, 1, 16'h0080, 9'h010, 0, al, aa, ak);
        step(0, 0, 16'h0000, 1, 16'h0080, 9'h010, 0, al, aa, ak);

        // Interrupt entry from FLAGS = 0302
        step(0, 1, 16'h0302, 0, 16'h0000, 9'h000, 0, al, aa, ak);
        step(1, 0, 16'h0000, 0, 16'h0000, 9'h000, 0, al, aa, ak);
        step(1, 0, 16'h0000, 0, 16'h0000, 9'h000, 0, al, aa, ak);
        step(1, 0, 16'h0000, 0, 16'h0000, 9'h000, 0, al, aa, ak);

        // Load held across a whole interrupt entry
        for (int i = 0; i < 3; i++) step(1, 1, 16'h0C41, 0, 16'h0000, 9'h000, 0, al, aa, ak);
        step(0, 1, 16'h0C41, 0, 16'h0000, 9'h000, 0, al, aa, ak);

        // STI shadow, boundary in the setting cycle ignored, CLI/STI mid-shadow restart
        step(0, 1, 16'h0000, 0, 16'h0000, 9'h000, 0, al, aa, ak);
        step(0, 0, 16'h0000, 1, 16'h0200, 9'h040, 1, al, aa, ak);
        step(0, 0, 16'h0000, 0, 16'h0000, 9'h000, 1, al, aa, ak);
        step(0, 0, 16'h0000, 1, 16'h0000, 9'h040, 0, al, aa, ak);
        step(0, 0, 16'h0000, 1, 16'h0200, 9'h040, 0, al, aa, ak);
        step(0, 0, 16'h0000, 0, 16'h0000, 9'h000, 1, al, aa, ak);
        step(0, 0, 16'h0000, 0, 16'h0000, 9'h000, 0, al, aa, ak);
        step(0, 0, 16'h0000, 0, 16'h0000, 9'h000, 1, al, aa, ak);
        step(0, 0, 16'h0000, 0, 16'h0000, 9'h000, 0, al, aa, ak);

        // Reset while in SAVE abandons the entry
        step(1, 0, 16'h0000, 0, 16'h0000, 9'h000, 0, al, aa, ak);
        @(posedge clk);
        #2;
        mon_en     = 1'b0;
        reset      = 1'b1;
        int_req    = 1'b0;
        load_valid = 1'b1;
        alu_valid  = 1'b1;
        #1;
        reset_outputs_check("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_ack", 32'(int_ack), 32'd0);
            chk("midrst_load_ready", 32'(load_ready), 32'd0);
        end
        @(negedge clk);
        reset      = 1'b0;
        load_valid = 1'b0;
        alu_valid  = 1'b0;
        model_reset();
        cyc_q.delete();
        wr_q.delete();
        mon_en = 1'b1;
        step(0, 0, 16'h0000, 0, 16'h0000, 9'h000, 0, al, aa, ak);
        step(0, 0, 16'h0000, 0, 16'h0000, 9'h000, 0, al, aa, ak);

        // Randomised traffic with requesters that hold until accepted
        r_iq = 1'b0; r_lv = 1'b0; r_av = 1'b0;
        r_ld = '0; r_af = '0; r_au = '0;
        for (int n = 0; n < 800; n++) begin
            if (!r_lv && $urandom_range(0, 2) == 0) begin
                r_lv = 1'b1;
                r_ld = 16'($urandom);
            end
            if (!r_av && $urandom_range(0, 1) == 0) begin
                r_av = 1'b1;
                r_af = 16'($urandom);
                r_au = 9'($urandom);
            end
            if (phase_m == 0 && !r_iq && $urandom_range(0, 11) == 0) r_iq = 1'b1;
            step(r_iq, r_lv, r_ld, r_av, r_af, r_au, ($urandom_range(0, 2) == 0), al, aa, ak);
            if (al) r_lv = 1'b0;
            if (aa) r_av = 1'b0;
            if (ak) r_iq = ($urandom_range(0, 3) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        chk("scoreboard_drained", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
